exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage in-order pipeline. Sits between the decode stage and the memory stage and instantiates the 12-bit one-hot ALU. It latches decoded operands through a valid/allowin handshake and drives the ALU each cycle. It issues the single data-SRAM request for loads and stores, and exports bypass and load-hazard information back to decode.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous kill from a later stage; discards the held instruction
- ds_to_es_valid  in  1  decode has a valid instruction on the ds_* inputs
- es_allowin  out  1  stage can accept an instruction this cycle
- ds_alu_op  in  12  one-hot ALU operation: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (bits 0..11)
- ds_src1, ds_src2  in  32  ALU operands
- ds_rkd_value  in  32  store data
- ds_pc  in  32  instruction PC
- ds_dest  in  5  destination register index
- ds_gr_we  in  1  writes a GPR
- ds_mem_we  in  1  word store
- ds_res_from_mem  in  1  word load
- ms_allowin  in  1  memory stage can accept
- es_to_ms_valid  out  1  valid instruction offered to memory stage
- es_pc, es_alu_result  out  32  held PC; ALU result of held operands
- es_dest  out  5; es_gr_we, es_res_from_mem  out  1  held control fields
- data_sram_en  out  1; data_sram_we  out  4; data_sram_addr, data_sram_wdata  out  32  data memory request
- es_fwd_valid  out  1; es_fwd_dest  out  5; es_fwd_data  out  32  bypass to decode
- es_load_hazard  out  1  held instruction is a load with a live destination

## Operation
- Registers: es_valid, req_sent, plus payload (alu_op, src1, src2, rkd_value, pc, dest, gr_we, mem_we, res_from_mem).
- es_ready_go is constantly 1. es_allowin = !es_valid || ms_allowin. es_to_ms_valid = es_valid.
- Clock-edge update order, highest priority first:
  - reset (async): es_valid=0, req_sent=0, all payload=0.
  - flush: es_valid<=0, req_sent<=0. Payload holds. Any ds_to_es_valid in that cycle is dropped.
  - es_allowin: es_valid<=ds_to_es_valid. Payload loads only when ds_to_es_valid=1. req_sent<=0.
  - otherwise, if data_sram_en=1: req_sent<=1.
- The ALU is driven by held alu_op/src1/src2, and es_alu_result is its result. Flags are unused.
- Memory request: data_sram_en = es_valid && (mem_we || res_from_mem) && !req_sent && !flush.
  - data_sram_we = {4{mem_we && data_sram_en}}.
  - data_sram_addr = es_alu_result, including low bits unmodified; only word accesses exist.
  - data_sram_wdata = held rkd_value.
- One request per instruction: a stalled memory op (ms_allowin=0) issues exactly once, in its first valid cycle.
- Bypass:
  - es_fwd_valid = es_valid && gr_we && (dest != 0).
  - es_fwd_dest = dest; es_fwd_data = es_alu_result.
  - es_load_hazard = es_fwd_valid && res_from_mem.

## Timing
- Latency: an instruction accepted at edge N appears on es_to_ms_valid and es_alu_result in cycle N+1. Both are combinational from registers, with no further register stage.
- Throughput: one instruction per cycle while ms_allowin=1.
- Stall: with ms_allowin=0 and es_valid=1, all outputs stay constant and data_sram_en is 0 after the first cycle.
- Simultaneous accept and hand-off is allowed: es_valid stays 1 with the new payload.
- Reset values of every output: es_allowin=1, es_to_ms_valid=0, data_sram_en=0, data_sram_we=0, es_fwd_valid=0, es_load_hazard=0. All 32/5-bit outputs are 0, except es_alu_result, which equals the ALU of zero operands with alu_op=0, i.e. 0.
- Reset mid-stall: the held instruction is lost and no request is reissued after reset deasserts.
- Flush in the same cycle as a pending first request suppresses that request (data_sram_en=0).

## Test plan
- Reset: assert reset mid-cycle -> es_to_ms_valid=0, es_allowin=1 and data_sram_en=0 immediately, before any clock edge.
- Back-to-back ALU: add 5+7, then sub 3-5, with ms_allowin=1 -> es_alu_result=0x0000000C, then 0xFFFFFFFE on consecutive cycles; es_fwd_valid=1 for dest=4 and 0 for dest=0.
- Stalled store: sw with src1=0x1000, src2=0x8, rkd=0xDEADBEEF, ms_allowin=0 for 3 cycles -> single cycle with data_sram_en=1, we=0xF, addr=0x1008, wdata=0xDEADBEEF; es_allowin=0 throughout the stall.
- Load hazard: lw to dest=9 -> es_load_hazard=1, es_fwd_dest=9, data_sram_we=0 and data_sram_en pulses once.
- Flush: flush asserted while a load is held and ds_to_es_valid=1 -> next cycle es_to_ms_valid=0, no SRAM request, the incoming instruction is dropped.
- Shifts/LUI sweep: sra 0x80000000 by 31 -> 0xFFFFFFFF; srl -> 0x00000001; lui src2=0x12345 -> 0x12345000; sltu 1<0xFFFFFFFF -> 1.

Source files
------------

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - decode/memory/data-SRAM signal bundle seen by the execute stage
interface exe_stage_if;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [11:0] ds_alu_op;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [31:0] ds_rkd_value;
    logic [31:0] ds_pc;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic        ds_mem_we;
    logic        ds_res_from_mem;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_res_from_mem;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        es_fwd_valid;
    logic [4:0]  es_fwd_dest;
    logic [31:0] es_fwd_data;
    logic        es_load_hazard;

    modport slave (
        input  ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_rkd_value, ds_pc,
               ds_dest, ds_gr_we, ds_mem_we, ds_res_from_mem, ms_allowin,
        output es_allowin, es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we,
               es_res_from_mem, data_sram_en, data_sram_we, data_sram_addr,
               data_sram_wdata, es_fwd_valid, es_fwd_dest, es_fwd_data, es_load_hazard
    );

    modport master (
        output ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_rkd_value, ds_pc,
               ds_dest, ds_gr_we, ds_mem_we, ds_res_from_mem, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we,
               es_res_from_mem, data_sram_en, data_sram_we, data_sram_addr,
               data_sram_wdata, es_fwd_valid, es_fwd_dest, es_fwd_data, es_load_hazard
    );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute pipeline stage with one-hot ALU, data-SRAM request and bypass
module exe_alu (
    input  logic [11:0] alu_op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] result_o
);
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sra_res;

    assign add_res  = src1_i + src2_i;
    assign sub_res  = src1_i - src2_i;
    assign slt_res  = $signed(src1_i) < $signed(src2_i);
    assign sltu_res = src1_i < src2_i;
    assign sra_res  = $unsigned($signed(src1_i) >>> src2_i[4:0]);

    // One-hot select: an all-zero op yields 0, which is the reset-visible result.
    assign result_o = ({32{alu_op_i[0]}}  & add_res)
                    | ({32{alu_op_i[1]}}  & sub_res)
                    | ({32{alu_op_i[2]}}  & {31'd0, slt_res})
                    | ({32{alu_op_i[3]}}  & {31'd0, sltu_res})
                    | ({32{alu_op_i[4]}}  & (src1_i & src2_i))
                    | ({32{alu_op_i[5]}}  & ~(src1_i | src2_i))
                    | ({32{alu_op_i[6]}}  & (src1_i | src2_i))
                    | ({32{alu_op_i[7]}}  & (src1_i ^ src2_i))
                    | ({32{alu_op_i[8]}}  & (src1_i << src2_i[4:0]))
                    | ({32{alu_op_i[9]}}  & (src1_i >> src2_i[4:0]))
                    | ({32{alu_op_i[10]}} & sra_res)
                    | ({32{alu_op_i[11]}} & {src2_i[19:0], 12'd0});
endmodule

module exe_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    exe_stage_if.slave bus
);
    logic        es_valid_q, es_valid_d;
    logic        req_sent_q, req_sent_d;
    logic [11:0] alu_op_q, alu_op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] rkd_value_q, rkd_value_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  dest_q, dest_d;
    logic        gr_we_q, gr_we_d;
    logic        mem_we_q, mem_we_d;
    logic        res_from_mem_q, res_from_mem_d;

    logic        es_allowin;
    logic        sram_en;
    logic        fwd_valid;
    logic        load_payload;
    logic [31:0] alu_result;

    exe_alu u_alu (
        .alu_op_i (alu_op_q),
        .src1_i   (src1_q),
        .src2_i   (src2_q),
        .result_o (alu_result)
    );

    assign es_allowin   = !es_valid_q || bus.ms_allowin;
    // req_sent keeps a stalled memory op from re-issuing on every held cycle.
    assign sram_en      = es_valid_q && (mem_we_q || res_from_mem_q) && !req_sent_q && !flush;
    assign fwd_valid    = es_valid_q && gr_we_q && (dest_q != 5'd0);
    assign load_payload = !flush && es_allowin && bus.ds_to_es_valid;

    always_comb begin
        es_valid_d = es_valid_q;
        req_sent_d = req_sent_q;
        if (flush) begin
            es_valid_d = 1'b0;
            req_sent_d = 1'b0;
        end else if (es_allowin) begin
            es_valid_d = bus.ds_to_es_valid;
            req_sent_d = 1'b0;
        end else if (sram_en) begin
            req_sent_d = 1'b1;
        end
    end

    always_comb begin
        alu_op_d       = alu_op_q;
        src1_d         = src1_q;
        src2_d         = src2_q;
        rkd_value_d    = rkd_value_q;
        pc_d           = pc_q;
        dest_d         = dest_q;
        gr_we_d        = gr_we_q;
        mem_we_d       = mem_we_q;
        res_from_mem_d = res_from_mem_q;
        if (load_payload) begin
            alu_op_d       = bus.ds_alu_op;
            src1_d         = bus.ds_src1;
            src2_d         = bus.ds_src2;
            rkd_value_d    = bus.ds_rkd_value;
            pc_d           = bus.ds_pc;
            dest_d         = bus.ds_dest;
            gr_we_d        = bus.ds_gr_we;
            mem_we_d       = bus.ds_mem_we;
            res_from_mem_d = bus.ds_res_from_mem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q     <= 1'b0;
            req_sent_q     <= 1'b0;
            alu_op_q       <= 12'd0;
            src1_q         <= 32'd0;
            src2_q         <= 32'd0;
            rkd_value_q    <= 32'd0;
            pc_q           <= 32'd0;
            dest_q         <= 5'd0;
            gr_we_q        <= 1'b0;
            mem_we_q       <= 1'b0;
            res_from_mem_q <= 1'b0;
        end else begin
            es_valid_q     <= es_valid_d;
            req_sent_q     <= req_sent_d;
            alu_op_q       <= alu_op_d;
            src1_q         <= src1_d;
            src2_q         <= src2_d;
            rkd_value_q    <= rkd_value_d;
            pc_q           <= pc_d;
            dest_q         <= dest_d;
            gr_we_q        <= gr_we_d;
            mem_we_q       <= mem_we_d;
            res_from_mem_q <= res_from_mem_d;
        end
    end

    assign bus.es_allowin      = es_allowin;
    assign bus.es_to_ms_valid  = es_valid_q;
    assign bus.es_pc           = pc_q;
    assign bus.es_alu_result   = alu_result;
    assign bus.es_dest         = dest_q;
    assign bus.es_gr_we        = gr_we_q;
    assign bus.es_res_from_mem = res_from_mem_q;
    assign bus.data_sram_en    = sram_en;
    assign bus.data_sram_we    = {4{mem_we_q && sram_en}};
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = rkd_value_q;
    assign bus.es_fwd_valid    = fwd_valid;
    assign bus.es_fwd_dest     = dest_q;
    assign bus.es_fwd_data     = alu_result;
    assign bus.es_load_hazard  = fwd_valid && res_from_mem_q;
endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed-vector bench for exe_stage
module tb_exe_stage;
    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    logic clk;
    logic reset;
    logic flush;
    int   n_vec;
    int   n_miss;
    int   n_req;

    exe_stage_if bus ();

    exe_stage dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] rkd, input logic [31:0] pc, input logic [4:0] dest,
                         input logic gr_we, input logic mem_we, input logic rfm);
        bus.ds_to_es_valid  = 1'b1;
        bus.ds_alu_op       = op;
        bus.ds_src1         = s1;
        bus.ds_src2         = s2;
        bus.ds_rkd_value    = rkd;
        bus.ds_pc           = pc;
        bus.ds_dest         = dest;
        bus.ds_gr_we        = gr_we;
        bus.ds_mem_we       = mem_we;
        bus.ds_res_from_mem = rfm;
    endtask

    logic [11:0] sw_op  [10];
    logic [31:0] sw_a   [10];
    logic [31:0] sw_b   [10];
    logic [31:0] sw_exp [10];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        sw_op  = '{OP_SRA, OP_SRL, OP_LUI, OP_SLTU, OP_SLT, OP_NOR, OP_XOR, OP_SLL, OP_AND, OP_OR};
        sw_a   = '{32'h80000000, 32'h80000000, 32'h0, 32'h1, 32'h1, 32'hF0F0F0F0,
                   32'hFF00FF00, 32'h1, 32'hFF00FF00, 32'hFF00FF00};
        sw_b   = '{32'd31, 32'd31, 32'h12345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0F0F0000,
                   32'h0FF00FF0, 32'd4, 32'h0FF00FF0, 32'h0FF00FF0};
        sw_exp = '{32'hFFFFFFFF, 32'h00000001, 32'h12345000, 32'h1, 32'h0, 32'h00000F0F,
                   32'hF0F0F0F0, 32'h10, 32'h0F000F00, 32'hFFF0FFF0};

        reset = 1'b0;
        flush = 1'b0;
        bus.ms_allowin = 1'b0;
        drive(12'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.ds_to_es_valid = 1'b0;

        // Asynchronous reset, observed before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
        check("rst_allowin", {31'd0, bus.es_allowin}, 32'd1);
        check("rst_sram_en", {31'd0, bus.data_sram_en}, 32'd0);
        check("rst_sram_we", {28'd0, bus.data_sram_we}, 32'd0);
        check("rst_fwd_valid", {31'd0, bus.es_fwd_valid}, 32'd0);
        check("rst_load_hazard", {31'd0, bus.es_load_hazard}, 32'd0);
        check("rst_alu_result", bus.es_alu_result, 32'd0);
        check("rst_pc", bus.es_pc, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Back-to-back ALU with forwarding
        bus.ms_allowin = 1'b1;
        drive(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h100, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        check("add_result", bus.es_alu_result, 32'h0000000C);
        check("add_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd1);
        check("add_fwd_valid", {31'd0, bus.es_fwd_valid}, 32'd1);
        check("add_fwd_dest", {27'd0, bus.es_fwd_dest}, 32'd4);
        check("add_fwd_data", bus.es_fwd_data, 32'h0000000C);
        check("add_pc", bus.es_pc, 32'h100);
        drive(OP_SUB, 32'd3, 32'd5, 32'd0, 32'h104, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("sub_result", bus.es_alu_result, 32'hFFFFFFFE);
        check("sub_fwd_valid_r0", {31'd0, bus.es_fwd_valid}, 32'd0);
        check("sub_pc", bus.es_pc, 32'h104);
        check("sub_sram_en", {31'd0, bus.data_sram_en}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(sw_op[i], sw_a[i], sw_b[i], 32'd0, 32'h108 + 32'(i * 4), 5'd1, 1'b1, 1'b0, 1'b0);
            step();
            check($sformatf("sweep_%0d", i), bus.es_alu_result, sw_exp[i]);
        end
        bus.ds_to_es_valid = 1'b0;
        step();
        check("idle_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);

        // Stalled store: exactly one request
        bus.ms_allowin = 1'b0;
        drive(OP_ADD, 32'h1000, 32'h8, 32'hDEADBEEF, 32'h200, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        bus.ds_to_es_valid = 1'b0;
        check("st_sram_en", {31'd0, bus.data_sram_en}, 32'd1);
        check("st_sram_we", {28'd0, bus.data_sram_we}, 32'hF);
        check("st_sram_addr", bus.data_sram_addr, 32'h1008);
        check("st_sram_wdata", bus.data_sram_wdata, 32'hDEADBEEF);
        check("st_allowin0", {31'd0, bus.es_allowin}, 32'd0);
        n_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.data_sram_en) n_req++;
            check("st_allowin", {31'd0, bus.es_allowin}, 32'd0);
            check("st_hold_pc", bus.es_pc, 32'h200);
        end
        check("st_req_count", 32'(n_req), 32'd1);
        bus.ms_allowin = 1'b1;
        step();
        check("st_drained", {31'd0, bus.es_to_ms_valid}, 32'd0);

        // Load hazard
        bus.ms_allowin = 1'b0;
        drive(OP_ADD, 32'h2000, 32'h4, 32'd0, 32'h300, 5'd9, 1'b1, 1'b0, 1'b1);
        step();
        bus.ds_to_es_valid = 1'b0;
        check("ld_hazard", {31'd0, bus.es_load_hazard}, 32'd1);
        check("ld_fwd_dest", {27'd0, bus.es_fwd_dest}, 32'd9);
        check("ld_sram_we", {28'd0, bus.data_sram_we}, 32'd0);
        check("ld_sram_en", {31'd0, bus.data_sram_en}, 32'd1);
        check("ld_sram_addr", bus.data_sram_addr, 32'h2004);
        step();
        check("ld_sram_en_once", {31'd0, bus.data_sram_en}, 32'd0);
        check("ld_hazard_hold", {31'd0, bus.es_load_hazard}, 32'd1);

        // Flush while load held and decode offers an instruction
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h500, 5'd3, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_sram_en_now", {31'd0, bus.data_sram_en}, 32'd0);
        step();
        flush = 1'b0;
        bus.ds_to_es_valid = 1'b0;
        check("fl_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
        check("fl_allowin", {31'd0, bus.es_allowin}, 32'd1);
        check("fl_sram_en", {31'd0, bus.data_sram_en}, 32'd0);
        check("fl_payload_hold", bus.es_pc, 32'h300);

        // Flush on the cycle of the first pending request
        drive(OP_ADD, 32'h40, 32'h0, 32'd0, 32'h600, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        bus.ds_to_es_valid = 1'b0;
        check("flp_sram_en_pre", {31'd0, bus.data_sram_en}, 32'd1);
        flush = 1'b1;
        #1;
        check("flp_sram_en_kill", {31'd0, bus.data_sram_en}, 32'd0);
        step();
        flush = 1'b0;
        check("flp_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
        check("flp_sram_en_post", {31'd0, bus.data_sram_en}, 32'd0);

        // Reset mid-stall
        drive(OP_ADD, 32'h40, 32'h0, 32'h55, 32'h700, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        bus.ds_to_es_valid = 1'b0;
        check("rs_sram_en_pre", {31'd0, bus.data_sram_en}, 32'd1);
        step();
        #2 reset = 1'b1;
        #1;
        check("rs_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
        check("rs_allowin", {31'd0, bus.es_allowin}, 32'd1);
        check("rs_sram_en", {31'd0, bus.data_sram_en}, 32'd0);
        check("rs_pc", bus.es_pc, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rs_no_reissue", {31'd0, bus.data_sram_en}, 32'd0);
        check("rs_valid_after", {31'd0, bus.es_to_ms_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
